inst_encoder: RTL and testbench

Streaming RV32IM instruction encoder, the counterpart to the decode-stage controller. It accepts field-level instruction requests (class, func3, registers, immediate) over a valid/ready handshake and packs them into 32-bit instruction words. Each word is buffered in a small FIFO and presented on a valid/ready output. Used by the self-test program generator and the debug instruction-injection path ahead of the fetch stage.

---
 rtl/inst_encoder.sv | 182 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32IM instruction encoder.
// Field-level requests are packed into 32-bit instruction words. Each word is
// queued in a small output FIFO and presented on a valid/ready interface.
// Illegal requests are always accepted. They raise a one-cycle enc_err pulse
// and bump a saturating error counter.
// Optional feature macro: INST_ENC_ILLEGAL_PASS_EN. When it is defined,
// illegal requests enqueue the defined-illegal word 32'h00000000 instead of
// being dropped.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_class,
  input  logic [2:0]       req_func3,
  input  logic             req_alt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_word,
  output logic             enc_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

`ifdef INST_ENC_ILLEGAL_PASS_EN
  localparam bit PASS_ILLEGAL = 1'b1;
`else
  localparam bit PASS_ILLEGAL = 1'b0;
`endif

  logic [31:0]      enc_word;
  logic             enc_illegal;
  logic [31:0]      push_word;
  logic             accept;
  logic             push;
  logic             pop;

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             enc_err_reg;
  logic [CNT_W-1:0] err_count_reg;

  // Combinational field packing and legality check for the current request
  always_comb begin
    enc_word    = 32'h0;
    enc_illegal = 1'b0;
    case (req_class)
      4'd0: begin
        enc_word = {(req_alt ? F7_ALT : 7'b0), req_rs2, req_rs1, req_func3, req_rd, OP_OP};
        if (req_alt && (req_func3 != 3'b000) && (req_func3 != 3'b101))
          enc_illegal = 1'b1;
      end
      4'd1: begin
        enc_word = {F7_MUL, req_rs2, req_rs1, req_func3, req_rd, OP_OP};
      end
      4'd2: begin
        if ((req_func3 == 3'b001) || (req_func3 == 3'b101)) begin
          // Shifts carry the shift amount in imm[4:0]; func7 comes from req_alt
          enc_word = {(req_alt ? F7_ALT : 7'b0), req_imm[4:0], req_rs1, req_func3, req_rd, OP_IMM};
          if (req_imm[11:5] != 7'b0)
            enc_illegal = 1'b1;
          if ((req_func3 == 3'b001) && req_alt)
            enc_illegal = 1'b1;
        end else begin
          enc_word = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_IMM};
        end
      end
      4'd3: begin
        enc_word = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_LOAD};
        if ((req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111))
          enc_illegal = 1'b1;
      end
      4'd4: begin
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
        if (req_func3 > 3'b010)
          enc_illegal = 1'b1;
      end
      4'd5: begin
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                    req_imm[4:1], req_imm[11], OP_BRANCH};
        if ((req_func3 == 3'b010) || (req_func3 == 3'b011))
          enc_illegal = 1'b1;
        if (req_imm[0])
          enc_illegal = 1'b1;
      end
      4'd6: begin
        enc_word = {req_imm[31:12], req_rd, OP_LUI};
      end
      4'd7: begin
        enc_word = {req_imm[31:12], req_rd, OP_AUIPC};
      end
      4'd8: begin
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
        if (req_imm[0])
          enc_illegal = 1'b1;
      end
      4'd9: begin
        // JALR only exists with func3 = 000, so the request's func3 is ignored
        enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      default: begin
        enc_word    = 32'h0;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Handshake and FIFO control; a full FIFO blocks even when a pop is pending
  always_comb begin
    req_ready  = (count_reg != FULL_CNT);
    inst_valid = (count_reg != '0);
    accept     = req_valid && req_ready;
    push       = accept && (!enc_illegal || PASS_ILLEGAL);
    pop        = inst_valid && inst_ready;
    push_word  = enc_illegal ? 32'h0 : enc_word;
    inst_word  = inst_valid ? mem[rd_ptr_reg] : 32'h0;
  end

  // FIFO storage; no reset needed because reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_word;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (!push && pop)
        count_reg <= count_reg - 1'b1;
    end
  end

  // Error pulse and saturating error counter for accepted illegal requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      enc_err_reg <= accept && enc_illegal;
      if (accept && enc_illegal && (err_count_reg != {CNT_W{1'b1}}))
        err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign enc_err   = enc_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed steps with a scoreboard queue.
// A second instance with CNT_W=2 shares all inputs. Its FIFO therefore tracks
// the first instance, and it is used only to observe error-counter saturation.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_class = '0;
  logic [2:0]  req_func3 = '0;
  logic        req_alt = 1'b0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        inst_ready = 1'b1;

  logic        req_ready, inst_valid, enc_err;
  logic [31:0] inst_word;
  logic [7:0]  err_count;

  logic        req_ready2, inst_valid2, enc_err2;
  logic [31:0] inst_word2;
  logic [1:0]  err_count2;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int err_pulses = 0;
  int cyc = 0;
  logic [31:0] sb [$];

`ifdef INST_ENC_ILLEGAL_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  inst_encoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_func3(req_func3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
    .enc_err(enc_err), .err_count(err_count)
  );

  inst_encoder #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_class(req_class), .req_func3(req_func3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid2), .inst_ready(inst_ready), .inst_word(inst_word2),
    .enc_err(enc_err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: each word leaving the FIFO is compared with the scoreboard
  always @(negedge clk) begin
    if (rst_n && enc_err)
      err_pulses++;
    if (rst_n && inst_valid && inst_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check("unexpected_word", inst_word, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("word", inst_word, e);
        $display("pop word=%h expected=%h", inst_word, e);
      end
    end
  end

  // Drive one request at posedge+1, wait (bounded) for req_ready, record the expectation at accept
  task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp, input bit legal);
    int n;
    req_valid = 1'b1; req_class = cls; req_func3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    if (legal) sb.push_back(exp);
    else if (PASS) sb.push_back(32'h0);
    $display("push class=%0d legal=%0d expected=%h", cls, legal, exp);
    req_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p0, c0;
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int c0;
    // Reset state
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst_word", inst_word, 32'h0);
    check("rst_enc_err", {31'b0, enc_err}, 32'h0);
    check("rst_err_count", {24'b0, err_count}, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // Single encodes; addi also checks no pass-through and one-cycle latency
    req_valid = 1'b1; req_class = 4'd2; req_func3 = 3'b000; req_alt = 1'b0;
    req_rd = 5'd1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
    @(negedge clk);
    check("no_passthrough", {31'b0, inst_valid}, 32'h0);
    @(posedge clk); #1;
    sb.push_back(32'h00500093);
    req_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", {31'b0, inst_valid}, 32'h1);
    @(posedge clk); #1;
    send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1);
    send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1);
    send(4'd1, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h027302B3, 1);
    send(4'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1);
    send(4'd5, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1);
    send(4'd6, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1);
    send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1);
    send(4'd3, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 32'd12, 32'h00C12203, 1);
    send(4'd9, 3'b111, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0, 32'h000280E7, 1);
    send(4'd7, 3'b000, 1'b0, 5'd6, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE317, 1);
    send(4'd2, 3'b101, 1'b1, 5'd3, 5'd1, 5'd0, 32'd4, 32'h4040D193, 1);
    wait_cycles(3);
    check("singles_drained", sb.size(), 32'd0);

    // Backpressure: four fill the FIFO, the fifth waits until a slot frees
    inst_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, k, (k << 20) | 32'h93, 1);
    @(negedge clk);
    check("full_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("no_bypass_when_full", {31'b0, req_ready}, 32'h0);
    send(4'd2, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, (32'd5 << 20) | 32'h93, 1);
    wait_cycles(8);
    check("bp_drained", sb.size(), 32'd0);

    // Illegal: class 12 then beq with odd offset
    p0 = pops;
    err_pulses = 0;
    send(4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 0);
    @(negedge clk);
    check("enc_err_pulse", {31'b0, enc_err}, 32'h1);
    @(posedge clk); #1;
    send(4'd5, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 32'h0, 0);
    wait_cycles(4);
    check("illegal_pulses", err_pulses, 32'd2);
    check("illegal_err_count", {24'b0, err_count}, 32'd2);
    check("illegal_words", pops - p0, PASS ? 32'd2 : 32'd0);

    // More illegal requests: dut2 (CNT_W=2) must saturate at 3
    send(4'd3, 3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 32'h0, 0);
    send(4'd4, 3'b011, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'h0, 0);
    send(4'd0, 3'b001, 1'b1, 5'd1, 5'd1, 5'd2, 32'd0, 32'h0, 0);
    send(4'd2, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'h20, 32'h0, 0);
    wait_cycles(3);
    check("err_count_6", {24'b0, err_count}, 32'd6);
    check("err_count_sat", {30'b0, err_count2}, 32'd3);
    check("illegal_drained", sb.size(), 32'd0);

    // Throughput: back-to-back pushes with inst_ready=1 take one cycle each
    p0 = pops;
    c0 = cyc;
    for (int k = 0; k < 8; k++)
      send(4'd2, 3'b000, 1'b0, 5'(k + 1), 5'd2, 5'd0, 32'(k * 3),
           (32'(k * 3) << 20) | (32'd2 << 15) | (32'(k + 1) << 7) | 32'h13, 1);
    check("throughput_cycles", cyc - c0, 32'd8);
    @(negedge clk);
    check("steady_ready", {31'b0, req_ready}, 32'h1);
    wait_cycles(3);
    check("throughput_words", pops - p0, 32'd8);
    check("throughput_drained", sb.size(), 32'd0);

    // Reset mid-stream with three entries queued
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send(4'd6, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'(k) << 12, (32'(k) << 12) | 32'h3B7, 1);
    check("pre_reset_valid", {31'b0, inst_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("midrst_inst_word", inst_word, 32'h0);
    check("midrst_err_count", {24'b0, err_count}, 32'h0);
    sb.delete();
    inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
    p0 = pops;
    wait_cycles(3);
    check("post_rst_no_words", pops - p0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
